// File: rtl/cache_mem_responder_if.sv
// cache_mem_responder_if
//   Bundles the instruction-cache and data-cache request/response signals
//   shared between the caches and the memory responder.
//
//   Signals:
//     iREN   - instruction fetch request            (cache -> mem)
//     iaddr  - instruction byte address             (cache -> mem)
//     iwait  - low only in the fetch acknowledge    (mem -> cache)
//     iload  - fetched word, valid when iwait=0     (mem -> cache)
//     dREN   - data read request                    (cache -> mem)
//     dWEN   - data write request                   (cache -> mem)
//     daddr  - data byte address                    (cache -> mem)
//     dstore - data write value                     (cache -> mem)
//     dwait  - low only in the data acknowledge     (mem -> cache)
//     dload  - read word, valid when dwait=0        (mem -> cache)
//
//   Modports: master = cache side, slave = memory side.

interface cache_mem_responder_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  iwait, iload, dwait, dload
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        output iwait, iload, dwait, dload
    );
endinterface

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   Memory-side responder for the instruction and data caches. Both caches
//   share one word-addressed storage array with a fixed access latency of
//   LAT wait cycles followed by a single acknowledge cycle. A preload port
//   lets a test seed storage directly.
//
//   Parameters:
//     DEPTH - storage size in 32-bit words (power of two)
//     LAT   - wait cycles before the acknowledge cycle (0..15)
//
//   Ports:
//     CLK    - clock, all state updates on the rising edge
//     RST    - synchronous active-high reset
//     bus    - cache_mem_responder_if.slave (iREN/iaddr/iwait/iload,
//              dREN/dWEN/daddr/dstore/dwait/dload)
//     ldWEN  - preload write strobe, honoured every cycle
//     ldaddr - preload byte address
//     lddata - preload value
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | arbitrate between caches, latch the winning request
//   BUSY  | count down latency, abort if the requester changes its request
//   ACK   | drive the granted port's wait low for one cycle, commit writes

module cache_mem_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    cache_mem_responder_if.slave    bus,
    input  logic                    ldWEN,
    input  logic [31:0]             ldaddr,
    input  logic [31:0]             lddata
);

    localparam int         IW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;

    // Latched grant: which port, which op, which word, what value.
    logic            last_data;
    logic            g_data;
    logic            g_wr;
    logic [IW-1:0]   g_idx;
    logic [31:0]     g_store;

    logic            grant;
    logic            grant_data;
    logic            hold_ok;

    logic            iwait_c, dwait_c;
    logic [31:0]     iload_c, dload_c;

    logic [31:0]     mem [DEPTH];

    logic [IW-1:0]   i_idx, d_idx, ld_idx;
    logic            d_req;

    // Upper address bits and byte offsets are ignored, so addresses alias
    // modulo DEPTH words.
    assign i_idx  = bus.iaddr[IW+1:2];
    assign d_idx  = bus.daddr[IW+1:2];
    assign ld_idx = ldaddr[IW+1:2];
    assign d_req  = bus.dREN | bus.dWEN;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.iaddr[31:IW+2], bus.iaddr[1:0],
                                bus.daddr[31:IW+2], bus.daddr[1:0],
                                ldaddr[31:IW+2],    ldaddr[1:0]};

    // The granted requester must keep presenting exactly the request that
    // was latched; any change abandons the access without side effects.
    always_comb begin
        hold_ok = 1'b0;
        if (g_data) begin
            hold_ok = d_req
                   && (bus.dWEN == g_wr)
                   && (d_idx == g_idx)
                   && (!g_wr || (bus.dstore == g_store));
        end else begin
            hold_ok = bus.iREN && (i_idx == g_idx);
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        grant      = 1'b0;
        grant_data = 1'b0;
        iwait_c    = 1'b1;
        dwait_c    = 1'b1;
        iload_c    = 32'd0;
        dload_c    = 32'd0;

        case (state)
            IDLE: begin
                // Data normally wins; after a data grant a pending fetch
                // goes first so instruction fetch cannot starve.
                if (d_req && !(last_data && bus.iREN)) begin
                    grant      = 1'b1;
                    grant_data = 1'b1;
                end else if (bus.iREN) begin
                    grant      = 1'b1;
                end

                if (grant) begin
                    if (LAT == 0) begin
                        state_n = ACK;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = LAT_M1;
                    end
                end
            end

            BUSY: begin
                if (!hold_ok) begin
                    state_n = IDLE;
                end else if (cnt == 4'd0) begin
                    state_n = ACK;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end

            ACK: begin
                state_n = IDLE;
                if (g_data) begin
                    dwait_c = 1'b0;
                    dload_c = g_wr ? 32'd0 : mem[g_idx];
                end else begin
                    iwait_c = 1'b0;
                    iload_c = mem[g_idx];
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last_data <= 1'b0;
            g_data    <= 1'b0;
            g_wr      <= 1'b0;
            g_idx     <= '0;
            g_store   <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (grant) begin
                g_data  <= grant_data;
                g_wr    <= grant_data & bus.dWEN;
                g_idx   <= grant_data ? d_idx : i_idx;
                g_store <= bus.dstore;
            end
            if (state == ACK) begin
                last_data <= g_data;
            end
        end
    end

    // Storage is never cleared. The cache write is placed after the preload
    // write so it takes priority when both hit the same word; a reset in the
    // ACK cycle suppresses the cache write.
    always_ff @(posedge CLK) begin
        if (ldWEN) begin
            mem[ld_idx] <= lddata;
        end
        if (!RST && (state == ACK) && g_data && g_wr) begin
            mem[g_idx] <= g_store;
        end
    end

    assign bus.iwait = iwait_c;
    assign bus.dwait = dwait_c;
    assign bus.iload = iload_c;
    assign bus.dload = dload_c;

endmodule
